countdown_timer: RTL and testbench
==================================

# countdown_timer

Countdown counterpart to the stopwatch. Loads a preset in whole seconds (0–99), counts down with millisecond resolution to zero, flags completion, and drives six active-low seven-segment digits in the same SS-MMM layout the board already uses. Sits beside the stopwatch at the top level and shares the switch, button and display pins.

## Interface
- CLK_FREQ, 50_000_000: input clock frequency in Hz.
- TICK_HZ, 1_000: countdown decrement rate in Hz. The divide ratio N = CLK_FREQ/TICK_HZ must be an integer ≥ 2.
- clk  in  1  system clock, the only clock.
- rst  in  1  reset, asynchronous, active-low.
- load  in  1  synchronous level; while high, the preset is (re)loaded.
- start  in  1  asynchronous button level, active-high; each rising edge is one start/stop request.
- preset_s  in  7  preset seconds; values above 99 clamp to 99.
- d0, d1, d2  out  7 each  ms digits (units, tens, hundreds).
- d3  out  7  separator digit.
- d4, d5  out  7 each  seconds digits (units, tens).
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- Segment encoding: bit6..bit0 = g..a, 0 = segment lit.

## Operation
- Registers: ms (10 bits, 0–999), s (7 bits, 0–99), state.
- States and transitions:
  - IDLE: start edge with {s,ms} ≠ 0 goes to RUN; with {s,ms} = 0 it is ignored.
  - RUN: each tick decrements the count. A start edge goes to PAUSE.
  - PAUSE: count held; a start edge goes to RUN.
  - DONE: count held at 0; start edges ignored.
- load in any state: next state IDLE, s = min(preset_s, 99), ms = 0.
- load has priority over a simultaneous start edge or tick. That start edge is discarded.
- Decrement on a tick in RUN:
  - ms > 0: ms − 1.
  - ms = 0, s > 0: ms = 999, s − 1.
  - ms = 0, s = 0: not reachable, because the transition to DONE happens on the tick that makes {s,ms} = 0.
- Display:
  - d0–d2 show ms and d4–d5 show s, each converted to BCD and then to segments.
  - d3 is constant 7'b0111111 (dash).
  - Blanking only under the blink feature (see Configuration).
- Reset values: state IDLE, s = 0, ms = 0, running = 0, done = 0. Digits show 00-000: d0–d2, d4, d5 = 7'b1000000; d3 = dash.

## Timing
- start input:
  - Passes through a 2-flop synchronizer, then a rising-edge detector.
  - The state change is visible on running exactly 3 clk cycles after the first rising clk edge that samples start high.
- Tick: one-cycle pulse every N clk cycles.
  - The divider clears on the IDLE→RUN transition, so the first decrement occurs N cycles after running rises.
  - The divider holds its count in PAUSE, so the remaining phase is preserved.
- running and done are registered and change in the same cycle as state.
- Display digits are combinational from the registers, so there is zero latency after a count change.
- Reset asserted mid-run: all registers return to reset values immediately. No pending start edge survives reset.

## Configuration
- COUNTDOWN_BLINK_EN:
  - Defined: while in DONE, all six digits blank (7'b1111111) for 250 ms then show the value for 250 ms, repeating. The toggle is derived from the tick counter; visible phase first.
  - Undefined: DONE shows 00-000 steadily and the blink logic is absent.

## Structure
- Shared package holds:
  - state encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3;
  - segment constants SEG_BLANK and SEG_DASH;
  - MAX_S=99 and MAX_MS=999.
- One sub-module, tick_gen: parameterized divider with clk, rst, clr and hold inputs and a one-cycle tick output.
- Binary-to-segment conversion reuses the team's existing BCD/segment block, with no new decoder.

## Test plan
Bench uses CLK_FREQ=10_000 and TICK_HZ=1_000, so N = 10.
- Reset release with preset_s=5, load=0: state IDLE, digits 00-000, running=0, done=0.
- Load 5, then a start pulse: running=1 at cycle 3; first tick 10 cycles later gives 04-999; reaching 00-000 takes 5000 ticks, then done=1 and running=0.
- Pause/resume: in RUN, start edge at 03-500 gives PAUSE and holds 03-500 for 200 cycles; the next start edge resumes and the following tick gives 03-499 with preserved phase.
- Load with preset_s=120 gives 99-000. Load and a start edge in the same cycle give IDLE with running=0.
- Load 0, then a start edge: stays in IDLE, done=0. In DONE, a start edge is ignored; load 3 returns to IDLE with 03-000.
- With COUNTDOWN_BLINK_EN, in DONE: digits alternate between 00-000 and all-blank every 250 ticks (2500 cycles).

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding, segment constants,
// count limits and the digit-to-segment decoder shared with the stopwatch.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_t;

    // Segment vectors are g..a, active-low (0 = segment lit)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam int unsigned MAX_S  = 99;
    localparam int unsigned MAX_MS = 999;

    // One BCD digit to active-low segments; non-decimal codes blank the digit
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Divide-by-N tick generator. clr restarts the period, hold freezes the phase.
// o_tick is a one-cycle pulse on the last count of each period.
module countdown_timer_tick_gen #(
    parameter int unsigned N = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_hold,
    output logic o_tick
);

    localparam int unsigned W = (N > 2) ? $clog2(N) : 1;

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = (r_cnt == W'(N - 1));
    assign o_tick = w_wrap & ~i_hold;

    // Period counter; clear wins over hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: preset in whole seconds, ms-resolution countdown, SS-MMM
// active-low seven-segment display. Define COUNTDOWN_BLINK_EN to blink the
// display at 250 ms on / 250 ms off while in DONE.
// CLK_FREQ / TICK_HZ must be an integer of at least 2.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned TICK_HZ  = 1_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic       i_start,
    input  logic [6:0] i_preset_s,
    output logic [6:0] o_d0,
    output logic [6:0] o_d1,
    output logic [6:0] o_d2,
    output logic [6:0] o_d3,
    output logic [6:0] o_d4,
    output logic [6:0] o_d5,
    output logic       o_running,
    output logic       o_done
);

    localparam int unsigned N = CLK_FREQ / TICK_HZ;

    state_t     r_state;
    logic [6:0] r_s;
    logic [9:0] r_ms;
    logic       r_running;
    logic       r_done;
    logic       r_sync1, r_sync2, r_start_prev, r_start_edge;

    logic       w_tick, w_clr, w_hold, w_nonzero, w_last, w_blank;
    logic [6:0] w_preset;
    logic [3:0] w_ms0, w_ms1, w_ms2, w_s0, w_s1;

    // Start button: 2-flop synchronizer, then registered rising-edge pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_start_prev <= 1'b0;
            r_start_edge <= 1'b0;
        end else begin
            r_sync1      <= i_start;
            r_sync2      <= r_sync1;
            r_start_prev <= r_sync2;
            r_start_edge <= r_sync2 & ~r_start_prev;
        end
    end

    assign w_preset  = (i_preset_s > 7'(MAX_S)) ? 7'(MAX_S) : i_preset_s;
    assign w_nonzero = (r_s != 7'd0) || (r_ms != 10'd0);
    assign w_last    = (r_s == 7'd0) && (r_ms == 10'd1);
    // Divider restarts exactly on the IDLE->RUN transition; phase frozen in PAUSE
    assign w_clr     = (r_state == StIdle) && r_start_edge && w_nonzero && !i_load;
    assign w_hold    = (r_state == StPause);

    countdown_timer_tick_gen #(
        .N (N)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_hold  (w_hold),
        .o_tick  (w_tick)
    );

    // Control FSM with count registers and registered status outputs.
    // Load overrides everything; a tick coinciding with a start edge in RUN
    // decrements first, and reaching zero takes precedence over pausing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_s       <= '0;
            r_ms      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else if (i_load) begin
            r_state   <= StIdle;
            r_s       <= w_preset;
            r_ms      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (r_start_edge && w_nonzero) begin
                        r_state   <= StRun;
                        r_running <= 1'b1;
                    end
                end
                StRun: begin
                    if (w_tick && w_last) begin
                        r_ms      <= '0;
                        r_state   <= StDone;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        if (w_tick) begin
                            if (r_ms == 10'd0) begin
                                r_ms <= 10'(MAX_MS);
                                r_s  <= r_s - 7'd1;
                            end else begin
                                r_ms <= r_ms - 10'd1;
                            end
                        end
                        if (r_start_edge) begin
                            r_state   <= StPause;
                            r_running <= 1'b0;
                        end
                    end
                end
                StPause: begin
                    if (r_start_edge) begin
                        r_state   <= StRun;
                        r_running <= 1'b1;
                    end
                end
                StDone: ;
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef COUNTDOWN_BLINK_EN
    localparam int unsigned BLINK_TICKS = TICK_HZ / 4;
    localparam int unsigned BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_blank;

    // Blink phase in DONE: visible first, toggling every quarter second of ticks
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (r_state != StDone) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (w_tick) begin
            if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
                r_blink_cnt <= '0;
                r_blank     <= ~r_blank;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_blank = r_blank;
`else
    assign w_blank = 1'b0;
`endif

    // Binary to BCD digits and segment patterns, combinational from the count
    always_comb begin
        w_ms0 = 4'(r_ms % 10'd10);
        w_ms1 = 4'((r_ms / 10'd10) % 10'd10);
        w_ms2 = 4'(r_ms / 10'd100);
        w_s0  = 4'(r_s % 7'd10);
        w_s1  = 4'(r_s / 7'd10);
        o_d0  = bcd_to_seg(w_ms0);
        o_d1  = bcd_to_seg(w_ms1);
        o_d2  = bcd_to_seg(w_ms2);
        o_d3  = SEG_DASH;
        o_d4  = bcd_to_seg(w_s0);
        o_d5  = bcd_to_seg(w_s1);
        if (w_blank) begin
            o_d0 = SEG_BLANK;
            o_d1 = SEG_BLANK;
            o_d2 = SEG_BLANK;
            o_d3 = SEG_BLANK;
            o_d4 = SEG_BLANK;
            o_d5 = SEG_BLANK;
        end
    end

    assign o_running = r_running;
    assign o_done    = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with N = 10 clocks per tick.
module tb_countdown_timer;

    localparam int unsigned CLK_FREQ = 10_000;
    localparam int unsigned TICK_HZ  = 1_000;
    localparam int          N        = CLK_FREQ / TICK_HZ;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       start;
    logic [6:0] preset;
    logic [6:0] d0, d1, d2, d3, d4, d5;
    logic       running, done;

    int n_cmp = 0;
    int n_bad = 0;

    countdown_timer #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (load),
        .i_start    (start),
        .i_preset_s (preset),
        .o_d0       (d0),
        .o_d1       (d1),
        .o_d2       (d2),
        .o_d3       (d3),
        .o_d4       (d4),
        .o_d5       (d5),
        .o_running  (running),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // {running, done, d5, d4, d3, d2, d1, d0}
    function automatic logic [43:0] vec(input logic r, input logic dn, input int s, input int ms);
        return {r, dn, seg(s / 10), seg(s % 10), 7'h3F, seg(ms / 100), seg((ms / 10) % 10),
                seg(ms % 10)};
    endfunction

    function automatic logic [43:0] act();
        return {running, done, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [43:0] got, input logic [43:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [6:0] p);
        preset = p;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    // Returns at the sample point just after the edge where the request takes effect
    task automatic press();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
    endtask

    // Reference model: mode, remaining milliseconds, cycles of RUN since last tick
    typedef enum {MIdle, MRun, MPause, MDone} mmode_t;
    mmode_t     m_mode;
    int         m_rem;
    int         m_phase;
    logic [4:0] m_hist;

    task automatic model_reset();
        m_mode  = MIdle;
        m_rem   = 0;
        m_phase = 0;
        m_hist  = '0;
    endtask

    task automatic model_step();
        logic req;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_hist = {m_hist[3:0], start};
        // A start rise sampled at edge k acts on the FSM at edge k+3
        req = m_hist[3] & ~m_hist[4];
        if (load) begin
            m_mode = MIdle;
            m_rem  = ((int'(preset) > 99) ? 99 : int'(preset)) * 1000;
        end else begin
            case (m_mode)
                MIdle: if (req && m_rem != 0) begin
                    m_mode  = MRun;
                    m_phase = 0;
                end
                MRun: begin
                    m_phase++;
                    if (m_phase == N) begin
                        m_phase = 0;
                        m_rem--;
                        if (m_rem == 0) m_mode = MDone;
                        else if (req) m_mode = MPause;
                    end else if (req) begin
                        m_mode = MPause;
                    end
                end
                MPause: if (req) m_mode = MRun;
                default: ;
            endcase
        end
    endtask

    typedef struct {
        logic [6:0] p;
        int         exp_s;
    } load_rec_t;

    load_rec_t tbl[8];
    logic [43:0] want;

    initial begin
        tbl[0] = '{7'd0,   0};
        tbl[1] = '{7'd5,   5};
        tbl[2] = '{7'd42,  42};
        tbl[3] = '{7'd99,  99};
        tbl[4] = '{7'd100, 99};
        tbl[5] = '{7'd120, 99};
        tbl[6] = '{7'd127, 99};
        tbl[7] = '{7'd10,  10};

        rst_n  = 1'b0;
        load   = 1'b0;
        start  = 1'b0;
        preset = 7'd5;
        step(2);
        check("in_reset", act(), vec(1'b0, 1'b0, 0, 0));
        rst_n = 1'b1;
        step(1);
        check("reset_release", act(), vec(1'b0, 1'b0, 0, 0));

        // Load clamping table
        for (int i = 0; i < 8; i++) begin
            do_load(tbl[i].p);
            check($sformatf("load_%0d", tbl[i].p), act(), vec(1'b0, 1'b0, tbl[i].exp_s, 0));
        end

        // Start latency and a full 5 s countdown
        do_load(7'd5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_e1", act(), vec(1'b0, 1'b0, 5, 0));
        step(1);
        check("start_e2", act(), vec(1'b0, 1'b0, 5, 0));
        step(1);
        check("start_e3", act(), vec(1'b0, 1'b0, 5, 0));
        step(1);
        check("start_e4", act(), vec(1'b1, 1'b0, 5, 0));
        step(N - 1);
        check("pre_first_tick", act(), vec(1'b1, 1'b0, 5, 0));
        step(1);
        check("first_tick", act(), vec(1'b1, 1'b0, 4, 999));
        step(5000 * N - N - 1);
        check("last_ms", act(), vec(1'b1, 1'b0, 0, 1));
        step(1);
        check("reach_done", act(), vec(1'b0, 1'b1, 0, 0));
`ifdef COUNTDOWN_BLINK_EN
        step(250 * N - 1);
        check("blink_visible", act(), vec(1'b0, 1'b1, 0, 0));
        step(1);
        check("blink_blank", act(), {2'b01, {6{7'h7F}}});
        step(250 * N);
        check("blink_visible2", act(), vec(1'b0, 1'b1, 0, 0));
`endif
        press();
        step(20);
        check("done_start_ignored", act(), vec(1'b0, 1'b1, 0, 0));
        do_load(7'd3);
        check("done_reload", act(), vec(1'b0, 1'b0, 3, 0));

        // Pause and resume with phase preserved
        do_load(7'd4);
        press();
        check("run_4", act(), vec(1'b1, 1'b0, 4, 0));
        step(500 * N);
        check("run_3500", act(), vec(1'b1, 1'b0, 3, 500));
        press();
        check("paused", act(), vec(1'b0, 1'b0, 3, 500));
        step(200);
        check("pause_hold", act(), vec(1'b0, 1'b0, 3, 500));
        press();
        check("resumed", act(), vec(1'b1, 1'b0, 3, 500));
        step(N - 5);
        check("resume_pre_tick", act(), vec(1'b1, 1'b0, 3, 500));
        step(1);
        check("resume_tick", act(), vec(1'b1, 1'b0, 3, 499));

        // Load coinciding with the start edge discards it
        do_load(7'd7);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("load_vs_start", act(), vec(1'b0, 1'b0, 7, 0));
        step(N + 5);
        check("load_vs_start_after", act(), vec(1'b0, 1'b0, 7, 0));

        // Zero preset: start ignored
        do_load(7'd0);
        press();
        check("zero_start", act(), vec(1'b0, 1'b0, 0, 0));
        step(30);
        check("zero_start_after", act(), vec(1'b0, 1'b0, 0, 0));

        // Randomized traffic against the reference model
        rst_n = 1'b0;
        start = 1'b0;
        load  = 1'b0;
        model_reset();
        step(1);
        rst_n = 1'b1;
        for (int c = 0; c < 8000; c++) begin
            want = {m_mode == MRun, m_mode == MDone, 42'd0};
            want[41:0] = vec(1'b0, 1'b0, m_rem / 1000, m_rem % 1000);
`ifdef COUNTDOWN_BLINK_EN
            if (m_mode == MDone) check("rand_status", {running, done}, want[43:42]);
            else check("rand", act(), want);
`else
            check("rand", act(), want);
`endif
            rst_n = ($urandom_range(0, 1999) != 0);
            load  = ($urandom_range(0, 149) == 0);
            if (load) begin
                preset = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(100, 127))
                                                     : 7'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 29) == 0) start = ~start;
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
